// File: rtl/fifo_write_arbiter_if.sv
// Producer/FIFO-side bundle for fifo_write_arbiter: producer requests and data in,
// grant, write strobe and FIFO data out.
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  // Handshake: the owner's req is its valid and ~fifo_full is the FIFO's ready; a beat
  // transfers exactly in the cycles where accept (== fifo_write) is high, and only then
  // may the owner advance its data and last.
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          fifo_full;
  logic [NUM_REQ-1:0]            grant;
  logic                          accept;
  logic                          fifo_write;
  logic [DATA_WIDTH-1:0]         fifo_datain;
  logic                          busy;
  logic                          dbg_state;

  modport master (
    output req, last, req_data, fifo_full,
    input  grant, accept, fifo_write, fifo_datain, busy, dbg_state
  );

  modport slave (
    input  req, last, req_data, fifo_full,
    output grant, accept, fifo_write, fifo_datain, busy, dbg_state
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers; each grant
// covers a burst of up to MAX_BURST beats, followed by one idle bubble cycle.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input logic                clock,
  input logic                reset,
  fifo_write_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_owner_q, last_owner_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic [IDX_W-1:0]      cand;
  logic [IDX_W-1:0]      win_idx;
  logic [DATA_WIDTH-1:0] owner_data;
  logic                  owner_req;
  logic                  owner_last;
  logic                  accept_w;
  logic [CNT_W-1:0]      beat_next;

  // Scan downward so the nearest requester after last_owner is the final assignment.
  always_comb begin
    cand    = '0;
    win_idx = last_owner_q;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(last_owner_q) + k) % NUM_REQ);
      if (bus.req[cand]) begin
        win_idx = cand;
      end
    end
  end

  // grant_q is one-hot or zero, so the mux output is zero whenever nobody owns the port.
  always_comb begin
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        owner_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    owner_req  = |(bus.req & grant_q);
    owner_last = |(bus.last & grant_q);
    accept_w   = (state_q == S_BURST) & owner_req & ~bus.fifo_full & ~reset;
    beat_next  = beat_cnt_q + 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          state_d    = S_BURST;
          grant_d    = NUM_REQ'(1) << win_idx;
          owner_d    = win_idx;
          beat_cnt_d = '0;
        end else begin
          grant_d = '0;
        end
      end
      S_BURST: begin
        if (!owner_req) begin
          state_d      = S_IDLE;
          grant_d      = '0;
          last_owner_d = owner_q;
        end else if (accept_w) begin
          beat_cnt_d = beat_next;
          if (owner_last || (beat_next == CNT_W'(MAX_BURST))) begin
            state_d      = S_IDLE;
            grant_d      = '0;
            last_owner_d = owner_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NUM_REQ - 1);
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.accept      = accept_w;
  assign bus.fifo_write  = accept_w;
  assign bus.fifo_datain = owner_data;
  assign bus.busy        = (state_q == S_BURST);
  assign bus.dbg_state   = (state_q == S_BURST);
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus randomized producer traffic,
// with expected writes predicted from round-robin burst rules into a scoreboard queue.
module tb_fifo_write_arbiter;
  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;
  localparam int EW   = DW + 3;

  logic clock;
  logic reset;

  fifo_write_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus();

  fifo_write_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MAXB)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // producer model state: each entry is {last, data}
  logic [DW:0]    prod_q [NR][$];
  logic [NR-1:0]  req_mask;
  logic [EW-1:0]  exp_q[$];
  logic [NR-1:0]  gseq[$];
  int             wcnt[$];
  int             m_last_owner;
  int             n_cmp;
  int             n_err;
  int             n_writes;

  logic [NR-1:0]  s_grant;
  logic           s_write;
  logic           s_accept;
  logic           s_busy;
  logic [DW-1:0]  s_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit any_pending();
    bit p;
    p = 1'b0;
    for (int i = 0; i < NR; i++) begin
      if (prod_q[i].size() > 0) p = 1'b1;
    end
    return p;
  endfunction

  // driver tasks
  task automatic apply_inputs();
    logic [NR-1:0]    r;
    logic [NR-1:0]    l;
    logic [NR*DW-1:0] d;
    logic [DW:0]      b;
    r = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < NR; i++) begin
      if (req_mask[i] && prod_q[i].size() > 0) begin
        b = prod_q[i][0];
        r[i] = 1'b1;
        l[i] = b[DW];
        d[i*DW +: DW] = b[DW-1:0];
      end
    end
    bus.req      = r;
    bus.last     = l;
    bus.req_data = d;
  endtask

  task automatic cycle();
    logic [NR-1:0] took;
    @(negedge clock);
    s_grant  = bus.grant;
    s_write  = bus.fifo_write;
    s_accept = bus.accept;
    s_busy   = bus.busy;
    s_data   = bus.fifo_datain;
    took     = bus.fifo_write ? bus.grant : '0;
    @(posedge clock);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (took[i] && prod_q[i].size() > 0) void'(prod_q[i].pop_front());
    end
    apply_inputs();
  endtask

  task automatic push_beat(input int p, input logic [DW-1:0] data, input logic lst);
    prod_q[p].push_back({lst, data});
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) prod_q[i].delete();
    exp_q.delete();
    gseq.delete();
    wcnt.delete();
    req_mask = '1;
  endtask

  // Reference model: serve producers round-robin from the last owner; each turn takes
  // beats until a last beat, MAX_BURST beats, or the producer runs dry.
  task automatic predict();
    int  ptr [NR];
    int  owner;
    int  idx;
    int  taken;
    bit  found;
    logic [DW:0] b;
    for (int i = 0; i < NR; i++) ptr[i] = 0;
    while (1) begin
      found = 1'b0;
      owner = 0;
      for (int k = 1; k <= NR; k++) begin
        idx = (m_last_owner + k) % NR;
        if (!found && ptr[idx] < prod_q[idx].size()) begin
          owner = idx;
          found = 1'b1;
        end
      end
      if (!found) break;
      taken = 0;
      while (ptr[owner] < prod_q[owner].size() && taken < MAXB) begin
        b = prod_q[owner][ptr[owner]];
        ptr[owner]++;
        taken++;
        exp_q.push_back({3'(owner), b[DW-1:0]});
        if (b[DW]) break;
      end
      m_last_owner = owner;
    end
  endtask

  task automatic do_reset();
    clear_all();
    bus.fifo_full = 1'b0;
    apply_inputs();
    reset = 1'b1;
    cycle();
    cycle();
    chk("rst_grant", 32'(s_grant), 0);
    chk("rst_busy", 32'(s_busy), 0);
    chk("rst_write", 32'(s_write), 0);
    chk("rst_accept", 32'(s_accept), 0);
    chk("rst_datain", 32'(s_data), 0);
    reset = 1'b0;
    m_last_owner = NR - 1;
  endtask

  task automatic run_until_empty(input int budget, input int full_pct);
    int n;
    n = 0;
    while ((any_pending() || exp_q.size() != 0) && n < budget) begin
      bus.fifo_full = ($urandom_range(0, 99) < full_pct);
      cycle();
      n++;
    end
    n_cmp++;
    if (any_pending() || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d expected writes outstanding after %0d cycles, required 0",
               exp_q.size(), n);
    end
    bus.fifo_full = 1'b0;
    repeat (3) cycle();
  endtask

  // scoreboard monitor
  logic [NR-1:0] prev_grant;
  initial prev_grant = '0;

  always @(negedge clock) begin
    logic [EW-1:0] e;
    logic [NR-1:0] eg;
    if (bus.fifo_write) begin
      n_cmp++;
      n_writes++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: write of %0h by grant %b, required no write",
                 bus.fifo_datain, bus.grant);
      end else begin
        e  = exp_q.pop_front();
        eg = NR'(1) << e[DW +: 3];
        if (bus.fifo_datain !== e[DW-1:0] || bus.grant !== eg || bus.accept !== 1'b1) begin
          n_err++;
          $display("FAIL sb_write: got data %0h grant %b accept %b, required data %0h grant %b accept 1",
                   bus.fifo_datain, bus.grant, bus.accept, e[DW-1:0], eg);
        end
      end
    end
    if (!reset && bus.grant != '0 && bus.grant != prev_grant) begin
      gseq.push_back(bus.grant);
      wcnt.push_back(0);
    end
    if (bus.fifo_write && wcnt.size() > 0) wcnt[wcnt.size()-1]++;
    prev_grant = reset ? '0 : bus.grant;
  end

  // stimulus
  initial begin
    logic [NR-1:0] t2_exp [5];
    logic [DW-1:0] b0;
    int            w0;
    n_cmp    = 0;
    n_err    = 0;
    n_writes = 0;
    reset    = 1'b1;
    req_mask = '1;
    bus.req       = '0;
    bus.last      = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;

    // single 3-beat burst from producer 0
    do_reset();
    push_beat(0, 8'h11, 1'b0);
    push_beat(0, 8'h22, 1'b0);
    push_beat(0, 8'h33, 1'b1);
    predict();
    w0 = n_writes;
    apply_inputs();
    cycle();
    chk("t1_idle_grant", 32'(s_grant), 0);
    cycle();
    chk("t1_grant_lat", 32'(s_grant), 32'h1);
    chk("t1_write_lat", 32'(s_write), 1);
    cycle();
    cycle();
    chk("t1_grant_hold", 32'(s_grant), 32'h1);
    cycle();
    chk("t1_grant_clr", 32'(s_grant), 0);
    chk("t1_write_clr", 32'(s_write), 0);
    chk("t1_nwrites", 32'(n_writes - w0), 3);
    run_until_empty(50, 0);

    // all producers requesting, no last: rotation with MAX_BURST bursts
    do_reset();
    for (int i = 0; i < NR; i++) begin
      for (int j = 0; j < ((i == 0) ? 2 * MAXB : MAXB); j++) begin
        push_beat(i, 8'($urandom_range(0, 255)), 1'b0);
      end
    end
    predict();
    apply_inputs();
    run_until_empty(200, 0);
    t2_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    chk("t2_ngrants", 32'(gseq.size()), 5);
    for (int k = 0; k < 5 && k < gseq.size(); k++) begin
      chk("t2_grant_seq", 32'(gseq[k]), 32'(t2_exp[k]));
      chk("t2_burst_len", 32'(wcnt[k]), MAXB);
    end

    // producer 2 stalled by fifo_full after its 2nd beat
    do_reset();
    for (int j = 0; j < 4; j++) push_beat(2, 8'(8'h40 + j), 1'b0);
    predict();
    apply_inputs();
    cycle();
    cycle();
    chk("t3_beat1", 32'(s_write), 1);
    cycle();
    chk("t3_beat2", 32'(s_write), 1);
    bus.fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t3_stall_write", 32'(s_write), 0);
      chk("t3_stall_grant", 32'(s_grant), 32'b0100);
    end
    bus.fifo_full = 1'b0;
    cycle();
    chk("t3_beat3", 32'(s_write), 1);
    cycle();
    chk("t3_beat4", 32'(s_write), 1);
    cycle();
    chk("t3_grant_clr", 32'(s_grant), 0);
    run_until_empty(50, 0);

    // producer 1 abandons after one beat; next arbitration starts at producer 2
    do_reset();
    b0 = 8'($urandom_range(0, 255));
    push_beat(1, b0, 1'b0);
    push_beat(1, 8'h5a, 1'b0);
    push_beat(1, 8'h5b, 1'b0);
    exp_q.push_back({3'd1, b0});
    apply_inputs();
    cycle();
    cycle();
    chk("t4_grant", 32'(s_grant), 32'b0010);
    chk("t4_write", 32'(s_write), 1);
    req_mask[1] = 1'b0;
    apply_inputs();
    cycle();
    chk("t4_drop_write", 32'(s_write), 0);
    cycle();
    chk("t4_grant_clr", 32'(s_grant), 0);
    prod_q[1].delete();
    req_mask = '1;
    for (int i = 0; i < 3; i++) push_beat(i, 8'(8'h70 + i), 1'b1);
    m_last_owner = 1;
    predict();
    apply_inputs();
    cycle();
    cycle();
    chk("t4_next_grant", 32'(s_grant), 32'b0100);
    run_until_empty(50, 0);

    // reset mid-burst on the 2nd beat
    do_reset();
    for (int i = 0; i < NR; i++) begin
      for (int j = 0; j < MAXB; j++) push_beat(i, 8'($urandom_range(0, 255)), 1'b0);
    end
    b0 = prod_q[0][0][DW-1:0];
    exp_q.push_back({3'd0, b0});
    apply_inputs();
    cycle();
    cycle();
    chk("t5_beat1", 32'(s_write), 1);
    reset = 1'b1;
    cycle();
    chk("t5_rst_write", 32'(s_write), 0);
    chk("t5_rst_accept", 32'(s_accept), 0);
    reset = 1'b0;
    m_last_owner = NR - 1;
    predict();
    cycle();
    chk("t5_post_grant", 32'(s_grant), 0);
    chk("t5_post_busy", 32'(s_busy), 0);
    cycle();
    chk("t5_first_grant", 32'(s_grant), 32'b0001);
    run_until_empty(200, 0);

    // single requester with last on every beat: one bubble per beat
    do_reset();
    for (int j = 0; j < 5; j++) push_beat(3, 8'(8'h90 + j), 1'b1);
    predict();
    apply_inputs();
    run_until_empty(100, 0);
    chk("t6_ngrants", 32'(gseq.size()), 5);
    for (int k = 0; k < gseq.size(); k++) begin
      chk("t6_grant", 32'(gseq[k]), 32'b1000);
      chk("t6_burst_len", 32'(wcnt[k]), 1);
    end

    // randomized packets with random backpressure
    do_reset();
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NR; i++) begin
        int npk;
        npk = $urandom_range(0, 2);
        for (int p = 0; p < npk; p++) begin
          int len;
          len = $urandom_range(1, 6);
          for (int j = 0; j < len; j++) begin
            push_beat(i, 8'($urandom_range(0, 255)), (j == len - 1));
          end
        end
      end
      predict();
      apply_inputs();
      run_until_empty(2000, 30);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
